// File: rtl/mrd_bank_sched_n.sv
// N-bank round-robin scheduler: steers input, the shared radix core and output
// onto memory banks in strict frame order, tracking a per-bank life cycle.
module mrd_bank_sched_n #(
  parameter int NBANK = 2,
  parameter int IDXW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sink_valid,
  input  logic                 sink_sop,
  input  logic                 sink_eop,
  output logic                 sink_ready,
  output logic [IDXW-1:0]      sw_in,
  output logic [IDXW-1:0]      sw_calc,
  output logic [IDXW-1:0]      sw_out,
  output logic [NBANK-1:0]     calc_start,
  input  logic [NBANK-1:0]     calc_done,
  output logic [NBANK-1:0]     drain_start,
  input  logic [NBANK-1:0]     drain_done,
  output logic [2*NBANK-1:0]   bank_state,
  output logic [3:0]           frames_busy,
  output logic [2:0]           err
);

  localparam int PW = (NBANK > 1) ? $clog2(NBANK) : 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    CALC  = 2'd2,
    DRAIN = 2'd3
  } bank_st_t;

  bank_st_t          state_q [NBANK];
  bank_st_t          state_d [NBANK];
  logic [NBANK-1:0]  issued_q, issued_d;
  logic [NBANK-1:0]  done_q, done_d;
  logic              busy_q, busy_d;
  logic [PW-1:0]     in_ptr_q, in_ptr_d;
  logic [PW-1:0]     calc_ptr_q, calc_ptr_d;
  logic [PW-1:0]     out_ptr_q, out_ptr_d;
  logic [2:0]        err_q, err_d;

  bank_st_t          cur_in;
  logic              accept;
  logic              calc_fire;
  logic              drain_fire;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(NBANK - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NBANK; k++) state_q[k] <= EMPTY;
      issued_q   <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      in_ptr_q   <= '0;
      calc_ptr_q <= '0;
      out_ptr_q  <= '0;
      err_q      <= '0;
    end else begin
      for (int k = 0; k < NBANK; k++) state_q[k] <= state_d[k];
      issued_q   <= issued_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      in_ptr_q   <= in_ptr_d;
      calc_ptr_q <= calc_ptr_d;
      out_ptr_q  <= out_ptr_d;
      err_q      <= err_d;
    end
  end

  // Only the out_ptr bank can be DRAIN, so a CALC bank there means the output is idle.
  always_comb begin
    cur_in     = state_q[in_ptr_q];
    sink_ready = (cur_in == EMPTY) || (cur_in == LOAD);
    accept     = sink_valid && sink_ready;
    calc_fire  = !busy_q && (state_q[calc_ptr_q] == CALC) && !issued_q[calc_ptr_q];
    drain_fire = (state_q[out_ptr_q] == CALC) && done_q[out_ptr_q];
  end

  always_comb begin
    for (int k = 0; k < NBANK; k++) state_d[k] = state_q[k];
    issued_d   = issued_q;
    done_d     = done_q;
    busy_d     = busy_q;
    in_ptr_d   = in_ptr_q;
    calc_ptr_d = calc_ptr_q;
    out_ptr_d  = out_ptr_q;
    err_d      = err_q;

    if (accept) begin
      if (cur_in == EMPTY && !sink_sop) begin
        err_d[0] = 1'b1;
      end else begin
        if (cur_in == LOAD && sink_sop) err_d[0] = 1'b1;
        if (sink_eop) begin
          state_d[in_ptr_q] = CALC;
          in_ptr_d          = nxt(in_ptr_q);
        end else begin
          state_d[in_ptr_q] = LOAD;
        end
      end
    end

    if (calc_fire) begin
      busy_d               = 1'b1;
      issued_d[calc_ptr_q] = 1'b1;
    end

    for (int k = 0; k < NBANK; k++) begin
      if (calc_done[k]) begin
        if (PW'(k) == calc_ptr_q && busy_q) begin
          busy_d     = 1'b0;
          done_d[k]  = 1'b1;
          calc_ptr_d = nxt(calc_ptr_q);
        end else begin
          err_d[1] = 1'b1;
        end
      end
    end

    if (drain_fire) state_d[out_ptr_q] = DRAIN;

    for (int k = 0; k < NBANK; k++) begin
      if (drain_done[k]) begin
        if (PW'(k) == out_ptr_q && state_q[k] == DRAIN) begin
          state_d[k]  = EMPTY;
          issued_d[k] = 1'b0;
          done_d[k]   = 1'b0;
          out_ptr_d   = nxt(out_ptr_q);
        end else begin
          err_d[2] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    calc_start  = '0;
    drain_start = '0;
    if (calc_fire)  calc_start[calc_ptr_q]  = 1'b1;
    if (drain_fire) drain_start[out_ptr_q]  = 1'b1;
  end

  always_comb begin
    bank_state  = '0;
    frames_busy = '0;
    for (int k = 0; k < NBANK; k++) begin
      bank_state[2*k +: 2] = state_q[k];
      if (state_q[k] != EMPTY) frames_busy = frames_busy + 4'd1;
    end
  end

  assign sw_in   = IDXW'(in_ptr_q);
  assign sw_calc = IDXW'(calc_ptr_q);
  assign sw_out  = IDXW'(out_ptr_q);
  assign err     = err_q;

endmodule

// File: tb/tb_mrd_bank_sched_n.sv
// Directed bench for mrd_bank_sched_n with four banks: vector table plus
// hand-written multi-cycle sequences (frame flow, full banks, reset mid-flight).
module tb_mrd_bank_sched_n;

  localparam int NB = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sink_valid = 1'b0;
  logic            sink_sop = 1'b0;
  logic            sink_eop = 1'b0;
  logic            sink_ready;
  logic [IW-1:0]   sw_in, sw_calc, sw_out;
  logic [NB-1:0]   calc_start, drain_start;
  logic [NB-1:0]   calc_done = '0;
  logic [NB-1:0]   drain_done = '0;
  logic [2*NB-1:0] bank_state;
  logic [3:0]      frames_busy;
  logic [2:0]      err;

  int checks = 0;
  int errors = 0;

  mrd_bank_sched_n #(.NBANK(NB), .IDXW(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_ready(sink_ready),
    .sw_in(sw_in), .sw_calc(sw_calc), .sw_out(sw_out),
    .calc_start(calc_start), .calc_done(calc_done),
    .drain_start(drain_start), .drain_done(drain_done),
    .bank_state(bank_state), .frames_busy(frames_busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v, s, e;
    logic [3:0] cd, dd;
    logic       rdy;
    logic [1:0] in_e, c_e, o_e;
    logic [3:0] cs, ds;
    logic [7:0] bs;
    logic [3:0] fb;
    logic [2:0] er;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic [1:0] in_e,
                         input logic [1:0] c_e, input logic [1:0] o_e,
                         input logic [3:0] cs, input logic [3:0] ds,
                         input logic [7:0] bs, input logic [3:0] fb, input logic [2:0] er);
    chk({tag, ".sink_ready"},  sink_ready,  rdy);
    chk({tag, ".sw_in"},       sw_in,       in_e);
    chk({tag, ".sw_calc"},     sw_calc,     c_e);
    chk({tag, ".sw_out"},      sw_out,      o_e);
    chk({tag, ".calc_start"},  calc_start,  cs);
    chk({tag, ".drain_start"}, drain_start, ds);
    chk({tag, ".bank_state"},  bank_state,  bs);
    chk({tag, ".frames_busy"}, frames_busy, fb);
    chk({tag, ".err"},         err,         er);
  endtask

  task automatic step(input logic v, input logic s, input logic e,
                      input logic [3:0] cd, input logic [3:0] dd);
    @(negedge clk);
    sink_valid = v;
    sink_sop   = s;
    sink_eop   = e;
    calc_done  = cd;
    drain_done = dd;
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    calc_done  = '0;
    drain_done = '0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_out(tag, 1'b1, 2'd0, 2'd0, 2'd0, 4'h0, 4'h0, 8'h00, 4'd0, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // table: spurious dones, bad input protocol, overlapping calc_done/eop
    vecs[0]  = '{1'b0,1'b0,1'b0,4'h0,4'h4, 1'b1,2'd0,2'd0,2'd0,4'h0,4'h0,8'h00,4'd0,3'b100};
    vecs[1]  = '{1'b0,1'b0,1'b0,4'h1,4'h0, 1'b1,2'd0,2'd0,2'd0,4'h0,4'h0,8'h00,4'd0,3'b110};
    vecs[2]  = '{1'b1,1'b0,1'b0,4'h0,4'h0, 1'b1,2'd0,2'd0,2'd0,4'h0,4'h0,8'h00,4'd0,3'b111};
    vecs[3]  = '{1'b1,1'b1,1'b0,4'h0,4'h0, 1'b1,2'd0,2'd0,2'd0,4'h0,4'h0,8'h01,4'd1,3'b111};
    vecs[4]  = '{1'b1,1'b1,1'b0,4'h0,4'h0, 1'b1,2'd0,2'd0,2'd0,4'h0,4'h0,8'h01,4'd1,3'b111};
    vecs[5]  = '{1'b1,1'b0,1'b1,4'h0,4'h0, 1'b1,2'd1,2'd0,2'd0,4'h1,4'h0,8'h02,4'd1,3'b111};
    vecs[6]  = '{1'b1,1'b1,1'b0,4'h0,4'h0, 1'b1,2'd1,2'd0,2'd0,4'h0,4'h0,8'h06,4'd2,3'b111};
    vecs[7]  = '{1'b1,1'b0,1'b1,4'h1,4'h0, 1'b1,2'd2,2'd1,2'd0,4'h2,4'h1,8'h0A,4'd2,3'b111};
    vecs[8]  = '{1'b0,1'b0,1'b0,4'h0,4'h4, 1'b1,2'd2,2'd1,2'd0,4'h0,4'h0,8'h0B,4'd2,3'b111};
    vecs[9]  = '{1'b0,1'b0,1'b0,4'h0,4'h1, 1'b1,2'd2,2'd1,2'd1,4'h0,4'h0,8'h08,4'd1,3'b111};
    vecs[10] = '{1'b0,1'b0,1'b0,4'h2,4'h0, 1'b1,2'd2,2'd2,2'd1,4'h0,4'h2,8'h08,4'd1,3'b111};
    vecs[11] = '{1'b0,1'b0,1'b0,4'h0,4'h0, 1'b1,2'd2,2'd2,2'd1,4'h0,4'h0,8'h0C,4'd1,3'b111};
    vecs[12] = '{1'b0,1'b0,1'b0,4'h0,4'h2, 1'b1,2'd2,2'd2,2'd2,4'h0,4'h0,8'h00,4'd0,3'b111};

    // 12-beat frame through load, compute and drain
    do_reset("rst0");
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    chk_out("f12.sop", 1'b1, 2'd0, 2'd0, 2'd0, 4'h0, 4'h0, 8'h01, 4'd1, 3'b000);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("f12.mid.bank_state", bank_state, 8'h01);
    step(1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
    chk_out("f12.eop", 1'b1, 2'd1, 2'd0, 2'd0, 4'h1, 4'h0, 8'h02, 4'd1, 3'b000);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk_out("f12.busy", 1'b1, 2'd1, 2'd0, 2'd0, 4'h0, 4'h0, 8'h02, 4'd1, 3'b000);
    step(1'b0, 1'b0, 1'b0, 4'h1, 4'h0);
    chk_out("f12.cdone", 1'b1, 2'd1, 2'd1, 2'd0, 4'h0, 4'h1, 8'h02, 4'd1, 3'b000);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk_out("f12.drain", 1'b1, 2'd1, 2'd1, 2'd0, 4'h0, 4'h0, 8'h03, 4'd1, 3'b000);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h1);
    chk_out("f12.ddone", 1'b1, 2'd1, 2'd1, 2'd1, 4'h0, 4'h0, 8'h00, 4'd0, 3'b000);

    do_reset("rst1");
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].cd, vecs[i].dd);
      chk_out($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].in_e, vecs[i].c_e, vecs[i].o_e,
              vecs[i].cs, vecs[i].ds, vecs[i].bs, vecs[i].fb, vecs[i].er);
    end

    // four back-to-back frames fill every bank
    do_reset("rst2");
    for (int f = 0; f < NB; f++) begin
      step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
      step(1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
    end
    chk_out("full", 1'b0, 2'd0, 2'd0, 2'd0, 4'h0, 4'h0, 8'hAA, 4'd4, 3'b000);
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    chk_out("full.blocked", 1'b0, 2'd0, 2'd0, 2'd0, 4'h0, 4'h0, 8'hAA, 4'd4, 3'b000);
    step(1'b0, 1'b0, 1'b0, 4'h1, 4'h0);
    chk_out("full.cdone0", 1'b0, 2'd0, 2'd1, 2'd0, 4'h2, 4'h1, 8'hAA, 4'd4, 3'b000);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk_out("full.drain0", 1'b0, 2'd0, 2'd1, 2'd0, 4'h0, 4'h0, 8'hAB, 4'd4, 3'b000);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h1);
    chk_out("full.freed", 1'b1, 2'd0, 2'd1, 2'd1, 4'h0, 4'h0, 8'hA8, 4'd3, 3'b000);

    // banks in LOAD, CALC and DRAIN, then reset mid-cycle
    step(1'b1, 1'b1, 1'b0, 4'h2, 4'h0);
    chk_out("mix.a", 1'b1, 2'd0, 2'd2, 2'd1, 4'h4, 4'h2, 8'hA9, 4'd4, 3'b000);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk_out("mix.b", 1'b1, 2'd0, 2'd2, 2'd1, 4'h0, 4'h0, 8'hAD, 4'd4, 3'b000);
    @(negedge clk);
    calc_done  = 4'h4;
    drain_done = 4'h2;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("midrst", 1'b1, 2'd0, 2'd0, 2'd0, 4'h0, 4'h0, 8'h00, 4'd0, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    calc_done  = '0;
    drain_done = '0;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk_out("postrst", 1'b1, 2'd0, 2'd0, 2'd0, 4'h0, 4'h0, 8'h00, 4'd0, 3'b000);
    step(1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
    chk_out("postrst.frame", 1'b1, 2'd1, 2'd0, 2'd0, 4'h1, 4'h0, 8'h02, 4'd1, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
